weight_serializer: RTL and testbench
====================================

# weight_serializer

- Upstream feeder for the bit-serial neuron multiplier (`Mult`).
- Accepts parallel (neuron, weight) pairs over a valid/ready handshake, buffering up to two pairs.
- Holds the neuron value stable and shifts the 16-bit weight out LSB-first on `Weight_bit`, one bit per clock, framed by `enable`.
- Clears the multiplier before each pair and strobes `prod_valid` when the multiplier's `out` is final, so the downstream accumulator can sample it.

## Interface

Parameters:

- `WIDTH`, 16, weight/neuron width and number of serial bits per pair.
- `MULT_LAT`, 1, cycles from the last serial bit to multiplier `out` being final; legal range 0..7.

Ports:

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pair offered.
- `in_ready`  out  1  pair can be accepted.
- `in_neuron`  in  WIDTH  neuron value.
- `in_weight`  in  WIDTH  weight value.
- `input_neuron`  out  WIDTH  neuron value to the multiplier.
- `Weight_bit`  out  1  serial weight bit to the multiplier.
- `enable`  out  1  multiplier enable, high only while bits are shifted.
- `mult_clear`  out  1  one-cycle clear of the multiplier accumulator.
- `prod_valid`  out  1  one-cycle strobe: multiplier `out` is final.
- `prod_zero`  out  1  qualifies `prod_valid`: product is known zero.
- `busy`  out  1  state is not IDLE, or the holding register is full.

## Operation

Buffering:

- Two registers: active (being serialized) and holding.
- `in_ready` = holding register empty.
- Transfer happens on a rising edge with `in_valid && in_ready`.
- A pair accepted in IDLE goes directly to the active register.
- Otherwise the pair goes to holding and moves to active on the DONE→CLEAR transition.

FSM states: IDLE, CLEAR, SHIFT, WAIT, DONE.

- IDLE: all strobes low. Go to CLEAR on accept.
- CLEAR: one cycle.
  - `mult_clear`=1, `enable`=0.
  - `input_neuron` loaded from the active pair.
  - Bit counter cleared.
- SHIFT: WIDTH cycles.
  - `enable`=1 and `Weight_bit` = active_weight[cnt].
  - cnt counts 0..WIDTH-1.
  - At cnt=WIDTH-1, go to WAIT, or to DONE if MULT_LAT=0.
- WAIT: MULT_LAT cycles with `enable`=0, `Weight_bit`=0.
- DONE: one cycle with `prod_valid`=1.
  - Go to CLEAR if holding is full, or if a pair is accepted in this cycle.
  - Otherwise go to IDLE.
- `input_neuron` holds its value from CLEAR through DONE. It keeps its last value in IDLE.
- `prod_zero` = 0 in the base build.

Reset:

- Every output is 0 in reset, except `in_ready`=1.
- Both registers are emptied and the counter is cleared.
- Reset mid-SHIFT aborts the pair. No `prod_valid` is issued for it.

Simultaneous events:

- Accept in DONE while holding is empty: the new pair loads directly into active for the next CLEAR.
- Accept while holding is full: not possible, because `in_ready`=0.
- `in_valid` may drop without a transfer. No pair is latched.

## Timing

Accept at edge 0 gives:

- CLEAR in cycle 1.
- SHIFT in cycles 2..WIDTH+1; bit i in cycle 2+i.
- WAIT in cycles WIDTH+2..WIDTH+1+MULT_LAT.
- `prod_valid` in cycle WIDTH+2+MULT_LAT. With defaults this is cycle 19.

Throughput:

- Back-to-back pairs: WIDTH+2+MULT_LAT cycles per pair (19 with defaults).
- No bubble as long as holding is full at DONE.

Output signalling:

- All outputs are registered.
- `enable` and `Weight_bit` change only on rising edges.

## Configuration

`WSER_ZERO_SKIP_EN`

- Defined: a pair whose weight is 0 skips SHIFT and WAIT.
  - Sequence is CLEAR (1 cycle) → DONE, with `prod_valid`=1 and `prod_zero`=1.
  - `enable` is never asserted for the pair.
  - `prod_valid` arrives in cycle 2 after accept.
- Undefined: zero weights are serialized like any other.
  - `prod_zero` is tied 0.

## Test plan

- Neuron 0x8800, weight 0x0400, defaults, single accept at edge 0:
  - `mult_clear` high in cycle 1.
  - `enable` high in cycles 2..17.
  - `Weight_bit` high only in cycle 12.
  - `input_neuron`=0x8800 in cycles 1..19.
  - `prod_valid` pulses in cycle 19.
- Three pairs offered back-to-back with `in_valid` held high:
  - `in_ready` drops after the second accept.
  - `prod_valid` pulses at cycles 19, 38 and 57.
  - Each pair's `mult_clear` immediately follows the previous DONE.
- Weight 0xFFFF: `Weight_bit` is high in all 16 SHIFT cycles.
  - With MULT_LAT=0, `prod_valid` arrives in cycle 18.
- Reset asserted in cycle 8 of a pair:
  - All outputs go 0 immediately and `in_ready`=1.
  - No `prod_valid` is issued.
  - The next accept restarts the sequence from CLEAR.
- Weight 0x0000:
  - With `WSER_ZERO_SKIP_EN`: `enable` never rises, and `prod_valid`=`prod_zero`=1 in cycle 2.
  - Without it: 16 SHIFT cycles with `Weight_bit`=0, and `prod_zero`=0.

Source files
------------

// File: rtl/weight_serializer.sv
// Bit-serial weight feeder for the neuron multiplier: two-entry pair buffer, LSB-first weight shift.
// Optional macro WSER_ZERO_SKIP_EN: zero weights bypass SHIFT/WAIT and report prod_zero.
module weight_serializer #(
  parameter int WIDTH    = 16,
  parameter int MULT_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_neuron,
  input  logic [WIDTH-1:0] in_weight,
  output logic [WIDTH-1:0] input_neuron,
  output logic             Weight_bit,
  output logic             enable,
  output logic             mult_clear,
  output logic             prod_valid,
  output logic             prod_zero,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [2:0]    WAIT_LAST = 3'((MULT_LAT > 0) ? MULT_LAT - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, WAIT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2:0]       wait_reg, wait_next;
  logic [WIDTH-1:0] act_neuron_reg, act_neuron_next;
  logic [WIDTH-1:0] act_weight_reg, act_weight_next;
  logic [WIDTH-1:0] hold_neuron_reg, hold_neuron_next;
  logic [WIDTH-1:0] hold_weight_reg, hold_weight_next;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] input_neuron_next;
  logic             weight_bit_next, enable_next, mult_clear_next;
  logic             prod_valid_next, prod_zero_next, busy_next;
  logic             accept, skip_shift;

  assign accept = in_valid && in_ready;

`ifdef WSER_ZERO_SKIP_EN
  assign skip_shift = (act_weight_reg == '0);
`else
  assign skip_shift = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    wait_next        = wait_reg;
    act_neuron_next  = act_neuron_reg;
    act_weight_next  = act_weight_reg;
    hold_neuron_next = hold_neuron_reg;
    hold_weight_next = hold_weight_reg;
    hold_full_next   = hold_full_reg;

    // A pair taken while the active slot is free (IDLE, or DONE with holding empty) bypasses holding.
    if (accept) begin
      if (state_reg == IDLE || state_reg == DONE) begin
        act_neuron_next = in_neuron;
        act_weight_next = in_weight;
      end else begin
        hold_neuron_next = in_neuron;
        hold_weight_next = in_weight;
        hold_full_next   = 1'b1;
      end
    end else if (state_reg == DONE && hold_full_reg) begin
      act_neuron_next = hold_neuron_reg;
      act_weight_next = hold_weight_reg;
      hold_full_next  = 1'b0;
    end

    case (state_reg)
      IDLE: if (accept) state_next = CLEAR;
      CLEAR: begin
        cnt_next   = '0;
        wait_next  = '0;
        state_next = skip_shift ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == CNT_LAST) state_next = (MULT_LAT == 0) ? DONE : WAIT;
        else                     cnt_next   = cnt_reg + 1'b1;
      end
      WAIT: begin
        if (wait_reg == WAIT_LAST) state_next = DONE;
        else                       wait_next  = wait_reg + 3'd1;
      end
      DONE: state_next = (hold_full_reg || accept) ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight from a flop.
    mult_clear_next   = (state_next == CLEAR);
    enable_next       = (state_next == SHIFT);
    weight_bit_next   = enable_next && act_weight_next[cnt_next];
    prod_valid_next   = (state_next == DONE);
    prod_zero_next    = prod_valid_next && skip_shift;
    input_neuron_next = (state_next == CLEAR) ? act_neuron_next : input_neuron;
    busy_next         = (state_next != IDLE) || hold_full_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      wait_reg        <= '0;
      act_neuron_reg  <= '0;
      act_weight_reg  <= '0;
      hold_neuron_reg <= '0;
      hold_weight_reg <= '0;
      hold_full_reg   <= 1'b0;
      in_ready        <= 1'b1;
      input_neuron    <= '0;
      Weight_bit      <= 1'b0;
      enable          <= 1'b0;
      mult_clear      <= 1'b0;
      prod_valid      <= 1'b0;
      prod_zero       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      wait_reg        <= wait_next;
      act_neuron_reg  <= act_neuron_next;
      act_weight_reg  <= act_weight_next;
      hold_neuron_reg <= hold_neuron_next;
      hold_weight_reg <= hold_weight_next;
      hold_full_reg   <= hold_full_next;
      in_ready        <= !hold_full_next;
      input_neuron    <= input_neuron_next;
      Weight_bit      <= weight_bit_next;
      enable          <= enable_next;
      mult_clear      <= mult_clear_next;
      prod_valid      <= prod_valid_next;
      prod_zero       <= prod_zero_next;
      busy            <= busy_next;
    end
  end

endmodule

// File: tb/tb_weight_serializer.sv
// Scoreboard bench for weight_serializer: accepted pairs predict done cycle and product,
// a negedge monitor rebuilds each serialized weight and compares at prod_valid.
module tb_weight_serializer;

  localparam int WIDTH    = 16;
  localparam int MULT_LAT = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_neuron = '0;
  logic [WIDTH-1:0] in_weight = '0;
  logic [WIDTH-1:0] input_neuron;
  logic             Weight_bit, enable, mult_clear, prod_valid, prod_zero, busy;

  weight_serializer #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_neuron(in_neuron), .in_weight(in_weight), .input_neuron(input_neuron),
    .Weight_bit(Weight_bit), .enable(enable), .mult_clear(mult_clear),
    .prod_valid(prod_valid), .prod_zero(prod_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] w;
    int               clr;
    int               done;
    bit               skip;
  } exp_t;

  exp_t exp_q[$];
  int   prev_done = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a pair starts (CLEAR) the cycle after it is accepted or after the previous DONE.
  always @(posedge clk) begin : recorder
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      prev_done = -100;
    end else if (in_valid && in_ready) begin
      e.n   = in_neuron;
      e.w   = in_weight;
      e.clr = (cyc + 1 > prev_done + 1) ? cyc + 1 : prev_done + 1;
`ifdef WSER_ZERO_SKIP_EN
      e.skip = (in_weight == '0);
`else
      e.skip = 1'b0;
`endif
      e.done = e.skip ? e.clr + 1 : e.clr + WIDTH + 1 + MULT_LAT;
      prev_done = e.done;
      exp_q.push_back(e);
    end
  end

  logic [WIDTH-1:0] m_w, m_n;
  logic [31:0]      m_prod;
  int               m_bits, m_clr, m_first, m_stray;
  bit               m_stable;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      m_bits = 0; m_stray = 0; m_first = -1;
    end else begin
      if (mult_clear) begin
        check("clear_enable_low", enable, 0);
        m_clr = cyc; m_n = input_neuron; m_w = '0; m_prod = '0;
        m_bits = 0; m_first = -1; m_stray = 0; m_stable = 1'b1;
      end
      if (input_neuron !== m_n) m_stable = 1'b0;
      if (enable) begin
        if (m_first < 0) m_first = cyc;
        if (m_bits < WIDTH) begin
          m_w[m_bits] = Weight_bit;
          if (Weight_bit) m_prod = m_prod + ({16'h0, m_n} << m_bits);
        end
        m_bits++;
      end else if (Weight_bit) begin
        m_stray++;
      end
      if (prod_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_prod_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("pair n=%h w=%h clr=%0d done=%0d", e.n, e.w, m_clr, cyc);
          check("done_cycle", cyc, e.done);
          check("clear_cycle", m_clr, e.clr);
          check("neuron", m_n, e.n);
          check("neuron_stable", m_stable, 1);
          check("weight_bits", m_w, e.skip ? '0 : e.w);
          check("bit_count", m_bits, e.skip ? 0 : WIDTH);
          check("first_enable", m_first, e.skip ? -1 : e.clr + 1);
          check("product", m_prod, 32'(e.n) * 32'(e.w));
          check("prod_zero", prod_zero, e.skip);
          check("stray_bits", m_stray, 0);
          check("busy_at_done", busy, 1);
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] w);
    logic rdy;
    int   t = 0;
    in_valid = 1'b1; in_neuron = n; in_weight = w;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); t++;
    end while (!rdy && t < 200);
    check("accept", rdy, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
    check({name, "_idle"}, {busy, in_ready, enable}, 3'b010);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [WIDTH-1:0] w;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {input_neuron, Weight_bit, enable, mult_clear, prod_valid, prod_zero, busy, in_ready},
          {16'h0, 6'b0, 1'b1});
    reset = 1'b1;
    @(posedge clk); #1;

    send(16'h8800, 16'h0400);
    wait_drain("single");

    send(16'h1234, 16'hA5A5);
    send(16'h00FF, 16'h0003);
    check("ready_low_after_second", in_ready, 0);
    send(16'h7FFF, 16'h8001);
    wait_drain("back_to_back");

    send(16'h0101, 16'hFFFF);
    wait_drain("all_ones");
    send(16'hBEEF, 16'h0000);
    wait_drain("zero_weight");

    // Abort a pair mid-SHIFT; no prod_valid may follow for it.
    send(16'h4321, 16'h5555);
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_abort_outputs",
          {input_neuron, Weight_bit, enable, mult_clear, prod_valid, prod_zero, busy, in_ready},
          {16'h0, 6'b0, 1'b1});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(16'h0F0F, 16'h00F1);
    wait_drain("after_reset");

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0:       w = '0;
        1:       w = '1;
        default: w = WIDTH'($urandom);
      endcase
      send(WIDTH'($urandom), w);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 25)) @(posedge clk);
      #1;
    end
    wait_drain("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
